i2c_reg_bridge: RTL and testbench

- Sits directly downstream of the I2C slave port. Consumes its device interface (devsel, rw_bit, rxbyte/valid, txbyte/deq, tx_nacked) and drives a simple request/acknowledge register bus into the NORA register space.
- Implements the standard pointer protocol. The first written byte of a transaction sets the register pointer. Later written bytes are register writes, and read bytes are register reads. The pointer auto-increments after each data byte.
- Prefetches the next read byte so txbyte_o is valid whenever the slave may consume it.

---
 rtl/nora_i2c_pkg.sv | 17 +
 rtl/i2c_reg_bridge.sv | 198 +++++++++++++++++++
 tb/tb_i2c_reg_bridge.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nora_i2c_pkg.sv
// Shared definitions for the I2C-to-register bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nora_i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_REQ  = 2'd1,
    ST_RD_REQ  = 2'd2,
    ST_RD_DONE = 2'd3
  } state_t;

  localparam int          TIMER_W          = 6;
  localparam logic [5:0]  ACK_TIMEOUT_DEF  = 6'd48;   // 1 us at 48 MHz
  localparam logic [7:0]  TIMEOUT_DATA_DEF = 8'hFF;

endpackage

// File: rtl/i2c_reg_bridge.sv
// Purpose: turns the I2C slave device interface into register-bus accesses using a pointer protocol.
// Latency: write request 1 cycle after rxbyte_v_i; read data = bus ack latency + 1 cycle after request.
// Backpressure: none towards the slave; bytes arriving while a bus access is open are dropped with err_o.
//
// Ports:
//   clk6x, resetn                 : 48 MHz clock, async active-low reset
//   devsel_i, rw_bit_i            : slave addressed / transfer direction (1 = master reads)
//   rxbyte_i, rxbyte_v_i          : received byte and its 1T strobe
//   txbyte_o, txbyte_deq_i        : prefetched transmit byte and slave consume strobe
//   tx_nacked_i                   : master NACKed the last transmitted byte
//   reg_addr_o, reg_wdata_o       : register bus address / write data
//   reg_wr_o, reg_rd_o            : request levels, held until reg_ack_i or timeout
//   reg_rdata_i, reg_ack_i        : read data and 1T completion
//   err_o                         : 1T pulse on overrun, underrun or bus timeout
module i2c_reg_bridge
  import nora_i2c_pkg::*;
#(
  parameter int         ADDR_W       = 8,
  parameter logic [5:0] ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
  parameter logic [7:0] TIMEOUT_DATA = TIMEOUT_DATA_DEF
) (
  input  logic              clk6x,
  input  logic              resetn,
  input  logic              devsel_i,
  input  logic              rw_bit_i,
  input  logic [7:0]        rxbyte_i,
  input  logic              rxbyte_v_i,
  output logic [7:0]        txbyte_o,
  input  logic              txbyte_deq_i,
  input  logic              tx_nacked_i,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [7:0]        reg_wdata_o,
  output logic              reg_wr_o,
  output logic              reg_rd_o,
  input  logic [7:0]        reg_rdata_i,
  input  logic              reg_ack_i,
  output logic              err_o
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_ptr_phase;
  logic [7:0]          r_txbuf;
  logic                r_txvalid;
  logic                r_pf_pend;
  logic                r_nack;
  logic                r_devsel_q;
  logic [TIMER_W-1:0]  r_timer;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_wdata;
  logic                r_wr;
  logic                r_rd;
  logic                r_err;

  logic w_dev_rise;
  logic w_idle;
  logic w_deq;
  logic w_ptr_load;
  logic w_overrun;
  logic w_collide;
  logic w_underrun;
  logic w_set_pf;
  logic w_tmo_hit;
  logic w_wr_start;
  logic w_rd_start;
  logic w_wr_end;
  logic w_wr_tmo;
  logic w_rd_ack;
  logic w_rd_tmo;

  assign w_dev_rise = devsel_i & ~r_devsel_q;
  assign w_idle     = (r_state == ST_IDLE);
  // A write byte wins over a simultaneous dequeue; the dequeue is ignored.
  assign w_deq      = txbyte_deq_i & ~rxbyte_v_i;
  assign w_ptr_load = rxbyte_v_i & w_idle & r_ptr_phase;
  assign w_overrun  = rxbyte_v_i & ~w_idle;
  assign w_collide  = rxbyte_v_i & txbyte_deq_i;
  assign w_underrun = w_deq & ~r_txvalid;
  // After a NACK the master is done reading; stop speculating further.
  assign w_set_pf   = (w_dev_rise & rw_bit_i) | (w_deq & ~r_nack);
  // Expire on the cycle the counter would reach zero, so the request stays up ACK_TIMEOUT cycles.
  assign w_tmo_hit  = (r_timer <= TIMER_W'(1));

  // Next-state and access strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_start  = 1'b0;
    w_rd_start  = 1'b0;
    w_wr_end    = 1'b0;
    w_wr_tmo    = 1'b0;
    w_rd_ack    = 1'b0;
    w_rd_tmo    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rxbyte_v_i && !r_ptr_phase) begin
          w_wr_start  = 1'b1;
          w_state_nxt = ST_WR_REQ;
        end else if (r_pf_pend && !rxbyte_v_i) begin
          w_rd_start  = 1'b1;
          w_state_nxt = ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        if (reg_ack_i) begin
          w_wr_end    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_tmo_hit) begin
          w_wr_end    = 1'b1;
          w_wr_tmo    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (reg_ack_i) begin
          w_rd_ack    = 1'b1;
          w_state_nxt = ST_RD_DONE;
        end else if (w_tmo_hit) begin
          w_rd_tmo    = 1'b1;
          w_state_nxt = ST_RD_DONE;
        end
      end
      ST_RD_DONE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      r_ptr       <= '0;
      r_ptr_phase <= 1'b1;
      r_txbuf     <= 8'h00;
      r_txvalid   <= 1'b0;
      r_pf_pend   <= 1'b0;
      r_nack      <= 1'b0;
      r_devsel_q  <= 1'b0;
      r_timer     <= '0;
      r_addr      <= '0;
      r_wdata     <= 8'h00;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_devsel_q <= devsel_i;
      r_err      <= w_overrun | w_collide | w_underrun | w_wr_tmo | w_rd_tmo;

      if (w_ptr_load)           r_ptr_phase <= 1'b0;
      else if (w_dev_rise)      r_ptr_phase <= 1'b1;

      if (w_ptr_load)               r_ptr <= ADDR_W'(rxbyte_i);
      else if (w_wr_end || w_deq)   r_ptr <= r_ptr + ADDR_W'(1);

      if (tx_nacked_i)          r_nack <= 1'b1;
      else if (w_dev_rise)      r_nack <= 1'b0;

      // Single pending slot: a request raised while another is being issued queues behind it.
      if (tx_nacked_i)          r_pf_pend <= 1'b0;
      else if (w_set_pf)        r_pf_pend <= 1'b1;
      else if (w_rd_start)      r_pf_pend <= 1'b0;

      if (w_wr_start || w_rd_start) begin
        r_timer <= ACK_TIMEOUT;
        r_addr  <= r_ptr;
      end else if ((r_state == ST_WR_REQ || r_state == ST_RD_REQ) && r_timer != '0) begin
        r_timer <= r_timer - TIMER_W'(1);
      end

      if (w_wr_start) begin
        r_wdata <= rxbyte_i;
        r_wr    <= 1'b1;
      end else if (w_wr_end) begin
        r_wr    <= 1'b0;
      end

      if (w_rd_start)                r_rd <= 1'b1;
      else if (w_rd_ack || w_rd_tmo) r_rd <= 1'b0;

      if (w_rd_ack)      r_txbuf <= reg_rdata_i;
      else if (w_rd_tmo) r_txbuf <= TIMEOUT_DATA;

      if (w_rd_start)                   r_txvalid <= 1'b0;
      else if (r_state == ST_RD_DONE)   r_txvalid <= 1'b1;
    end
  end

  assign txbyte_o    = r_txbuf;
  assign reg_addr_o  = r_addr;
  assign reg_wdata_o = r_wdata;
  assign reg_wr_o    = r_wr;
  assign reg_rd_o    = r_rd;
  assign err_o       = r_err;

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// Bench for i2c_reg_bridge: directed I2C-side stimulus, a register-bus responder with
// programmable ack delay, and a scoreboard that checks bus requests, dequeued bytes and error pulses.
// Stimulus drives at posedge+1; the monitor and responder act on the falling edge.
`timescale 1ns/1ps
module tb_i2c_reg_bridge;

  localparam int EV_WR = 0, EV_RD = 1, EV_TX = 2, EV_ERR = 3;

  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] dat;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  logic       clk6x = 1'b0;
  logic       resetn = 1'b0;
  logic       devsel_i = 1'b0;
  logic       rw_bit_i = 1'b0;
  logic [7:0] rxbyte_i = 8'h00;
  logic       rxbyte_v_i = 1'b0;
  logic [7:0] txbyte_o;
  logic       txbyte_deq_i = 1'b0;
  logic       tx_nacked_i = 1'b0;
  logic [7:0] reg_addr_o;
  logic [7:0] reg_wdata_o;
  logic       reg_wr_o;
  logic       reg_rd_o;
  logic [7:0] reg_rdata_i = 8'h00;
  logic       reg_ack_i = 1'b0;
  logic       err_o;

  logic [7:0] mem [256];
  int         ack_dly = 1;
  bit         ack_en  = 1'b1;

  always #10 clk6x = ~clk6x;

  i2c_reg_bridge #(.ADDR_W(8)) dut (
    .clk6x       (clk6x),
    .resetn      (resetn),
    .devsel_i    (devsel_i),
    .rw_bit_i    (rw_bit_i),
    .rxbyte_i    (rxbyte_i),
    .rxbyte_v_i  (rxbyte_v_i),
    .txbyte_o    (txbyte_o),
    .txbyte_deq_i(txbyte_deq_i),
    .tx_nacked_i (tx_nacked_i),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_wr_o    (reg_wr_o),
    .reg_rd_o    (reg_rd_o),
    .reg_rdata_i (reg_rdata_i),
    .reg_ack_i   (reg_ack_i),
    .err_o       (err_o)
  );

  function automatic string kname(int k);
    case (k)
      EV_WR:   return "WR";
      EV_RD:   return "RD";
      EV_TX:   return "TX";
      default: return "ERR";
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(int k, logic [7:0] a, logic [7:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic take(int k, logic [7:0] a, logic [7:0] d);
    ev_t e;
    bit  bad;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s: got addr=%02h dat=%02h, expected no event", kname(k), a, d);
    end else begin
      e = exp_q.pop_front();
      bad = (e.kind != k) ||
            (k == EV_WR && (e.addr !== a || e.dat !== d)) ||
            (k == EV_RD && e.addr !== a) ||
            (k == EV_TX && e.dat !== d);
      if (bad) begin
        failures++;
        $display("FAIL event_%s: got %s addr=%02h dat=%02h, expected %s addr=%02h dat=%02h",
                 kname(e.kind), kname(k), a, d, kname(e.kind), e.addr, e.dat);
      end
    end
  endtask

  // Monitor: every request rise, slave dequeue and error pulse consumes one expected event.
  initial begin : monitor
    logic p_wr, p_rd;
    p_wr = 1'b0; p_rd = 1'b0;
    forever begin
      @(negedge clk6x);
      if (resetn) begin
        if (reg_wr_o && !p_wr) take(EV_WR, reg_addr_o, reg_wdata_o);
        if (reg_rd_o && !p_rd) take(EV_RD, reg_addr_o, 8'h00);
        if (txbyte_deq_i)      take(EV_TX, 8'h00, txbyte_o);
        if (err_o)             take(EV_ERR, 8'h00, 8'h00);
      end
      p_wr = reg_wr_o;
      p_rd = reg_rd_o;
    end
  end

  // Register-bus model: acks ack_dly cycles after a request appears.
  initial begin : responder
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk6x);
      if (!resetn) begin
        reg_ack_i = 1'b0; cnt = 0;
      end else if (reg_ack_i) begin
        reg_ack_i = 1'b0; cnt = 0;
      end else if ((reg_wr_o || reg_rd_o) && ack_en) begin
        cnt++;
        if (cnt >= ack_dly) begin
          reg_ack_i = 1'b1;
          if (reg_wr_o) mem[reg_addr_o] = reg_wdata_o;
          else          reg_rdata_i = mem[reg_addr_o];
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk6x);
    #1;
  endtask

  task automatic rx(logic [7:0] b);
    rxbyte_i = b; rxbyte_v_i = 1'b1;
    cyc(1);
    rxbyte_v_i = 1'b0;
  endtask

  task automatic deq();
    txbyte_deq_i = 1'b1;
    cyc(1);
    txbyte_deq_i = 1'b0;
  endtask

  task automatic nack();
    tx_nacked_i = 1'b1;
    cyc(1);
    tx_nacked_i = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int w, n;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h20] = 8'h01; mem[8'h21] = 8'h02; mem[8'h22] = 8'h03; mem[8'h23] = 8'h04;

    cyc(3);
    chk("rst_wr", reg_wr_o, 0);
    chk("rst_rd", reg_rd_o, 0);
    chk("rst_addr", reg_addr_o, 0);
    chk("rst_wdata", reg_wdata_o, 0);
    chk("rst_tx", txbyte_o, 0);
    chk("rst_err", err_o, 0);
    resetn = 1'b1;
    cyc(2);

    // Write transaction (address byte 0x84 is absorbed by the slave): ptr 0x10, data AA, 55.
    devsel_i = 1'b1; rw_bit_i = 1'b0; cyc(1);
    rx(8'h10); cyc(2);
    push(EV_WR, 8'h10, 8'hAA); rx(8'hAA); cyc(4);
    push(EV_WR, 8'h11, 8'h55); rx(8'h55); cyc(4);
    devsel_i = 1'b0; cyc(2);
    // A read start prefetches at the current pointer, exposing it.
    push(EV_RD, 8'h12, 8'h00);
    devsel_i = 1'b1; rw_bit_i = 1'b1; cyc(6);
    devsel_i = 1'b0; cyc(2);

    // Pointer 0x20, repeated start, read three bytes ACK, ACK, NACK.
    devsel_i = 1'b1; rw_bit_i = 1'b0; cyc(1);
    rx(8'h20); cyc(2);
    devsel_i = 1'b0; cyc(1);
    push(EV_RD, 8'h20, 8'h00);
    devsel_i = 1'b1; rw_bit_i = 1'b1; cyc(6);
    push(EV_TX, 8'h00, 8'h01); push(EV_RD, 8'h21, 8'h00); deq(); cyc(6);
    push(EV_TX, 8'h00, 8'h02); push(EV_RD, 8'h22, 8'h00); deq(); cyc(6);
    push(EV_TX, 8'h00, 8'h03); push(EV_RD, 8'h23, 8'h00); deq(); cyc(1);
    nack(); cyc(6);
    devsel_i = 1'b0; cyc(2);
    push(EV_RD, 8'h23, 8'h00);
    devsel_i = 1'b1; rw_bit_i = 1'b1; cyc(6);
    devsel_i = 1'b0; cyc(2);

    // Overrun: slow bus ack, second data byte arrives 4 cycles after the first.
    devsel_i = 1'b1; rw_bit_i = 1'b0; cyc(1);
    rx(8'h40); cyc(2);
    ack_dly = 10;
    push(EV_WR, 8'h40, 8'h11); rx(8'h11); cyc(3);
    push(EV_ERR, 8'h00, 8'h00); rx(8'h22); cyc(15);
    devsel_i = 1'b0; cyc(2);
    ack_dly = 1;

    // Read timeout at the pointer left by the overrun case (0x41).
    ack_en = 1'b0;
    push(EV_RD, 8'h41, 8'h00); push(EV_ERR, 8'h00, 8'h00);
    devsel_i = 1'b1; rw_bit_i = 1'b1;
    w = 0;
    while (!reg_rd_o && w < 20) begin @(negedge clk6x); w++; end
    chk("tmo_rd_started", reg_rd_o, 1);
    n = 0;
    while (reg_rd_o && n < 200) begin n++; @(negedge clk6x); end
    chk("tmo_rd_hold_cycles", n, 48);
    cyc(2);
    chk("tmo_txbyte", txbyte_o, 8'hFF);
    ack_en = 1'b1;
    devsel_i = 1'b0; cyc(2);

    // Pointer wrap: 0xFF then 0x00.
    devsel_i = 1'b1; rw_bit_i = 1'b0; cyc(1);
    rx(8'hFF); cyc(2);
    push(EV_WR, 8'hFF, 8'hA1); rx(8'hA1); cyc(4);
    push(EV_WR, 8'h00, 8'hB2); rx(8'hB2); cyc(4);
    devsel_i = 1'b0; cyc(2);

    // Asynchronous reset in the middle of a write request.
    ack_dly = 10;
    devsel_i = 1'b1; rw_bit_i = 1'b0; cyc(1);
    rx(8'h30); cyc(2);
    push(EV_WR, 8'h30, 8'h77); rx(8'h77); cyc(3);
    chk("wr_pending_before_reset", reg_wr_o, 1);
    #3 resetn = 1'b0;
    #1;
    chk("async_rst_wr", reg_wr_o, 0);
    chk("async_rst_addr", reg_addr_o, 0);
    cyc(2);
    devsel_i = 1'b0;
    resetn = 1'b1;
    ack_dly = 1;
    cyc(2);
    chk("post_rst_tx", txbyte_o, 8'h00);
    chk("post_rst_err", err_o, 0);
    // Pointer restarts at 0; reg 0x00 holds 0xB2 from the wrap case.
    push(EV_RD, 8'h00, 8'h00);
    devsel_i = 1'b1; rw_bit_i = 1'b1; cyc(6);
    push(EV_TX, 8'h00, 8'hB2); push(EV_RD, 8'h01, 8'h00); deq(); cyc(6);
    nack(); cyc(2);
    devsel_i = 1'b0;
    cyc(10);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
